// File: rtl/dispatch_ctrl_slice_if.sv
// Control bundles exchanged around the decode/dispatch pipeline slice.
//
// control_decode_io   : control fields produced by decode for one instruction.
//   modport out       : the slice's view of the bundle (all fields are inputs).
// control_dispatch_io : control fields handed to the dispatch stage.
//   modport in        : the slice's view of the bundle (all fields are outputs).

interface control_decode_io;
    logic       jump;
    logic       rs_fpu;
    logic [3:0] dispatch_unit;
    logic [1:0] alu_op;
    logic [2:0] imm_src;
    logic       alu_src;
    logic       store_src;
    logic       reg_write;
    logic       fpu_reg_write;
    logic [1:0] result_src;
    logic [2:0] funct3;
    logic       op_5_xor_6;

    modport out (
        input jump, rs_fpu, dispatch_unit, alu_op, imm_src, alu_src, store_src,
              reg_write, fpu_reg_write, result_src, funct3, op_5_xor_6
    );
endinterface

interface control_dispatch_io;
    logic       jump;
    logic       rs_fpu;
    logic       alu_src;
    logic       store_src;
    logic       reg_write;
    logic       fpu_reg_write;
    logic [1:0] result_src;
    logic [3:0] alu_control;

    modport in (
        output jump, rs_fpu, alu_src, store_src, reg_write, fpu_reg_write,
               result_src, alu_control
    );
endinterface

// File: rtl/dispatch_ctrl_slice.sv
// Pipeline slice between decode and dispatch. Decodes alu_control from
// alu_op/funct3, then buffers the control bundle in a two-entry skid buffer
// (main register drives the outputs, skid register catches the one entry that
// can arrive while the head is stalled). in_ready depends only on registered
// state, so there is no combinational path from out_ready back to decode.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous drop of all buffered entries
//   dec                 decode control bundle (input)
//   funct7_5            instruction bit 30
//   in_tag/in_valid     incoming entry tag and valid
//   in_ready            slice can accept an entry
//   disp                dispatch control bundle of the head entry (output)
//   out_dispatch_unit   target unit select of the head entry
//   out_tag/out_valid   head entry tag and valid
//   out_ready           dispatch consumes the head entry
//
// state   | meaning
// S_EMPTY | no entries buffered
// S_ONE   | main register holds the head, skid empty
// S_TWO   | main and skid both hold entries; in_ready is low

module dispatch_ctrl_slice #(
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    control_decode_io.out    dec,
    input  logic             funct7_5,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             in_valid,
    output logic             in_ready,
    control_dispatch_io.in   disp,
    output logic [3:0]       out_dispatch_unit,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef struct packed {
        logic             jump;
        logic             rs_fpu;
        logic             alu_src;
        logic             store_src;
        logic             reg_write;
        logic             fpu_reg_write;
        logic [1:0]       result_src;
        logic [3:0]       alu_control;
        logic [3:0]       dispatch_unit;
        logic [TAG_W-1:0] tag;
    } entry_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_ONE   = 2'b01,
        S_TWO   = 2'b11
    } occ_t;

    occ_t   r_state;
    occ_t   w_state_nxt;
    entry_t r_main;
    entry_t r_skid;
    entry_t w_in_entry;
    logic   [3:0] w_alu_control;
    logic   w_accept;
    logic   w_pop;
    logic   w_main_ld;
    logic   w_main_from_skid;
    logic   w_skid_ld;

    // imm_src is part of the decode bundle but has no consumer after dispatch.
    logic   w_unused;
    assign w_unused = ^dec.imm_src;

    always_comb begin
        w_alu_control = 4'b0000;
        case (dec.alu_op)
            2'b01: w_alu_control = 4'b0001;
            2'b10: begin
                case (dec.funct3)
                    3'b000: w_alu_control = (dec.op_5_xor_6 & funct7_5) ? 4'b0001 : 4'b0000;
                    3'b001: w_alu_control = 4'b0010;
                    3'b010: w_alu_control = 4'b0011;
                    3'b011: w_alu_control = 4'b0100;
                    3'b100: w_alu_control = 4'b0101;
                    3'b101: w_alu_control = funct7_5 ? 4'b0111 : 4'b0110;
                    3'b110: w_alu_control = 4'b1000;
                    default: w_alu_control = 4'b1001;
                endcase
            end
            2'b11: begin
                case (dec.funct3)
                    3'b000: w_alu_control = 4'b1010;
                    3'b001: w_alu_control = 4'b1011;
                    3'b100: w_alu_control = 4'b1100;
                    3'b101: w_alu_control = 4'b1101;
                    3'b110: w_alu_control = 4'b1110;
                    3'b111: w_alu_control = 4'b1111;
                    default: w_alu_control = 4'b0000;
                endcase
            end
            default: w_alu_control = 4'b0000;
        endcase
    end

    always_comb begin
        w_in_entry.jump          = dec.jump;
        w_in_entry.rs_fpu        = dec.rs_fpu;
        w_in_entry.alu_src       = dec.alu_src;
        w_in_entry.store_src     = dec.store_src;
        w_in_entry.reg_write     = dec.reg_write;
        w_in_entry.fpu_reg_write = dec.fpu_reg_write;
        w_in_entry.result_src    = dec.result_src;
        w_in_entry.alu_control   = w_alu_control;
        w_in_entry.dispatch_unit = dec.dispatch_unit;
        w_in_entry.tag           = in_tag;
    end

    assign in_ready  = (r_state != S_TWO);
    assign out_valid = (r_state != S_EMPTY);
    assign w_accept  = in_valid & in_ready & ~flush;
    assign w_pop     = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Main only loads when it is empty or its head leaves this cycle, so the
    // outputs stay stable under backpressure. Skid loads only while main holds.
    always_comb begin
        w_state_nxt      = r_state;
        w_main_ld        = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_ld        = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = S_ONE;
                    w_main_ld   = 1'b1;
                end
            end
            S_ONE: begin
                case ({w_accept, w_pop})
                    2'b10: begin
                        w_state_nxt = S_TWO;
                        w_skid_ld   = 1'b1;
                    end
                    2'b01: w_state_nxt = S_EMPTY;
                    2'b11: w_main_ld   = 1'b1;
                    default: w_state_nxt = S_ONE;
                endcase
            end
            S_TWO: begin
                if (w_pop) begin
                    w_state_nxt      = S_ONE;
                    w_main_ld        = 1'b1;
                    w_main_from_skid = 1'b1;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
        // Flush wins over everything; a pop in the same cycle still counts as
        // delivered because dispatch sampled the head before this edge.
        if (flush) begin
            w_state_nxt = S_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_main_ld) begin
                r_main <= w_main_from_skid ? r_skid : w_in_entry;
            end
            if (w_skid_ld) begin
                r_skid <= w_in_entry;
            end
        end
    end

    assign disp.jump          = r_main.jump;
    assign disp.rs_fpu        = r_main.rs_fpu;
    assign disp.alu_src       = r_main.alu_src;
    assign disp.store_src     = r_main.store_src;
    assign disp.reg_write     = r_main.reg_write;
    assign disp.fpu_reg_write = r_main.fpu_reg_write;
    assign disp.result_src    = r_main.result_src;
    assign disp.alu_control   = r_main.alu_control;
    assign out_dispatch_unit  = r_main.dispatch_unit;
    assign out_tag            = r_main.tag;

endmodule

// File: doc/dispatch_ctrl_slice.md
Name: dispatch_ctrl_slice

Overview:
- Pipeline slice between decode and dispatch.
- Consumes the decode-side control bundle and produces the dispatch-side control bundle, including the 4-bit alu_control decoded from alu_op/funct3.
- Two-entry skid buffer with a valid/ready handshake on each side and a synchronous flush for branch mispredict and jump redirect.
- Sustains one instruction per cycle with no combinational ready path from dispatch back to decode.

Parameters:
- TAG_W, 6, width of the instruction tag carried alongside the control bundle.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  drop all buffered entries
- dec  in  control_decode_io.out  decode control bundle (jump, rs_fpu, dispatch_unit, alu_op, imm_src, alu_src, store_src, reg_write, fpu_reg_write, result_src, funct3, op_5_xor_6)
- funct7_5  in  1  instruction bit 30
- in_tag  in  TAG_W  instruction tag
- in_valid  in  1  decode presents an entry
- in_ready  out  1  slice can accept
- disp  out  control_dispatch_io.in  dispatch control bundle
- out_dispatch_unit  out  4  target unit select
- out_tag  out  TAG_W  tag of the head entry
- out_valid  out  1  head entry valid
- out_ready  in  1  dispatch consumes the head entry

Behaviour:
- Handshakes:
  - Accept when in_valid & in_ready & !flush.
  - Pop when out_valid & out_ready.
- Storage: main register (head, drives outputs) plus skid register.
- Payload captured per entry: jump, rs_fpu, alu_src, store_src, reg_write, fpu_reg_write, result_src, decoded alu_control, dispatch_unit, tag. imm_src is not forwarded.
- in_ready = !skid_valid (registered state only; no path from out_ready).
- Accept with main empty, or main popping in the same cycle: entry goes to main.
- Accept with main full and not popping: entry goes to skid.
- Pop with skid valid: skid moves to main; skid clears unless an accept refills it this cycle.
- FIFO order is preserved at all times. The skid is only written while main holds and is not popping.
- All registers update on the rising edge of clk.
- Latency: an accepted entry appears on the outputs the next cycle.
- flush (synchronous, highest priority):
  - Next cycle main_valid=0 and skid_valid=0.
  - An input offered in the flush cycle is dropped.
  - A pop in the flush cycle still completes.
- Reset (async, rst_n low):
  - out_valid=0, skid_valid=0, so in_ready=1.
  - All disp fields, out_dispatch_unit and out_tag are 0.
  - Reset asserted mid-transfer discards both entries immediately.
- Payload on out_* while out_valid=0 is don't-care, but must not change while out_valid=1 and out_ready=0.
- alu_control decode (combinational at input, registered with the entry):
  - alu_op 00: 0000 ADD.
  - alu_op 01: 0001 SUB.
  - alu_op 10, by funct3:
    - 000: SUB if op_5_xor_6 & funct7_5, else ADD.
    - 001: 0010 SLL.
    - 010: 0011 SLT.
    - 011: 0100 SLTU.
    - 100: 0101 XOR.
    - 101: 0111 SRA if funct7_5, else 0110 SRL.
    - 110: 1000 OR.
    - 111: 1001 AND.
  - alu_op 11, by funct3:
    - 000: 1010 EQ.
    - 001: 1011 NE.
    - 100: 1100 LT.
    - 101: 1101 GE.
    - 110: 1110 LTU.
    - 111: 1111 GEU.
    - 010/011: ADD.
- Occupancy states: EMPTY (0 entries), ONE (main only), TWO (main+skid).
  - EMPTY→ONE on accept.
  - ONE→TWO on accept without pop.
  - ONE→EMPTY on pop without accept.
  - TWO→ONE on pop.
  - Any state→EMPTY on flush.
  - ONE with accept and pop in the same cycle stays ONE.
  - TWO with in_ready=0: no accept.

Test Plan:
- Reset mid-stream: two entries held, out_ready=0, pulse rst_n low → out_valid=0, in_ready=1, disp.alu_control=0, out_tag=0 without a clock edge.
- Streaming: out_ready=1, tags 1,2,3,4 presented back-to-back → out_tag 1,2,3,4 on consecutive cycles, each one cycle after accept, in_ready stays 1.
- Backpressure: out_ready=0, push tags 5,6 → in_ready=0 after the second accept, out_tag holds 5. Raise out_ready → 5, then 6 delivered, in_ready returns 1 the cycle after 5 pops.
- ALU decode:
  - alu_op=10, funct3=000, op_5_xor_6=1, funct7_5=1 → alu_control=0001; same with op_5_xor_6=0 → 0000.
  - funct3=101, funct7_5=1 → 0111.
  - alu_op=11, funct3=110 → 1110.
- Flush priority: slice holds two entries, flush=1 with in_valid=1, tag=9 → next cycle out_valid=0, in_ready=1, tag 9 never appears.
- Simultaneous accept and pop in ONE: head tag 3 popped while tag 4 accepted → next cycle out_tag=4, skid empty, in_ready=1.
